// File: rtl/hopfield_engine.sv
// Sequential Hopfield recall engine: one weight multiply-accumulate per cycle.
// Optional HOPFIELD_ZERO_DIAG_EN forces the self-connection term (m==k) to zero.
module hopfield_engine #(
  parameter  int N        = 25,
  parameter  int WW       = 8,
  parameter  int MAX_ITER = 15,
  localparam int AW       = $clog2(N*N),
  localparam int SW       = WW + $clog2(N) + 1,
  localparam int IW       = $clog2(MAX_ITER + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [WW-1:0] wr_data,
  input  logic                 ld_en,
  input  logic [N-1:0]         ld_pattern,
  input  logic                 start,
  input  logic                 mode,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [IW-1:0]        iter_count,
  output logic [N-1:0]         neuros
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] LAST     = KW'(N - 1);
  localparam logic [IW-1:0] ITER_LIM = IW'(MAX_ITER);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_UPDATE, S_CHECK, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d, m_q, m_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic signed [SW-1:0]   acc_q, acc_d;
  logic [N-1:0]           neuros_q, neuros_d, nxt_q, nxt_d;
  logic                   chg_q, chg_d, mode_q, mode_d;
  logic [IW-1:0]          iter_q, iter_d;
  logic                   conv_q, conv_d, busy_q, busy_d, done_q, done_d;

  logic signed [WW-1:0]   w_mem [N*N];
  logic signed [WW-1:0]   w_rd;
  logic signed [SW-1:0]   w_ext;
  logic                   s_m, new_bit;
  logic [IW-1:0]          iter_inc;

  // Weight store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst && state_q == S_IDLE && wr_en && (32'(wr_addr) < 32'(N*N)))
      w_mem[wr_addr] <= wr_data;
  end

  always_comb begin
    w_rd  = w_mem[addr_q];
    w_ext = {{(SW-WW){w_rd[WW-1]}}, w_rd};
`ifdef HOPFIELD_ZERO_DIAG_EN
    if (k_q == m_q) w_ext = '0;
`endif
    // In synchronous runs neuros only moves in CHECK, so it is the snapshot.
    s_m      = neuros_q[m_q];
    new_bit  = !acc_q[SW-1] && (acc_q != '0);
    iter_inc = iter_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    m_d      = m_q;
    addr_d   = addr_q;
    acc_d    = acc_q;
    neuros_d = neuros_q;
    nxt_d    = nxt_q;
    chg_d    = chg_q;
    mode_d   = mode_q;
    iter_d   = iter_q;
    conv_d   = conv_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_en) neuros_d = ld_pattern;
        if (start) begin
          mode_d  = mode;
          iter_d  = '0;
          conv_d  = 1'b0;
          chg_d   = 1'b0;
          k_d     = '0;
          m_d     = '0;
          addr_d  = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d  = acc_q + (s_m ? w_ext : -w_ext);
        addr_d = addr_q + 1'b1;
        if (m_q == LAST) begin
          m_d     = '0;
          state_d = S_UPDATE;
        end else begin
          m_d = m_q + 1'b1;
        end
      end
      S_UPDATE: begin
        if (new_bit != neuros_q[k_q]) chg_d = 1'b1;
        if (mode_q) neuros_d[k_q] = new_bit;
        else        nxt_d[k_q]    = new_bit;
        acc_d = '0;
        if (k_q == LAST) begin
          state_d = S_CHECK;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = S_MAC;
        end
      end
      S_CHECK: begin
        iter_d = iter_inc;
        if (!mode_q) neuros_d = nxt_q;
        if (!chg_q || iter_inc == ITER_LIM) begin
          conv_d  = !chg_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          chg_d   = 1'b0;
          k_d     = '0;
          addr_d  = '0;
          state_d = S_MAC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      m_q      <= '0;
      addr_q   <= '0;
      acc_q    <= '0;
      neuros_q <= '0;
      nxt_q    <= '0;
      chg_q    <= 1'b0;
      mode_q   <= 1'b0;
      iter_q   <= '0;
      conv_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      m_q      <= m_d;
      addr_q   <= addr_d;
      acc_q    <= acc_d;
      neuros_q <= neuros_d;
      nxt_q    <= nxt_d;
      chg_q    <= chg_d;
      mode_q   <= mode_d;
      iter_q   <= iter_d;
      conv_q   <= conv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign converged  = conv_q;
  assign iter_count = iter_q;
  assign neuros     = neuros_q;

endmodule

// File: tb/tb_hopfield_engine.sv
// Directed bench for hopfield_engine at N=25, WW=8, MAX_ITER=15.
module tb_hopfield_engine;
  localparam int N  = 25;
  localparam int WW = 8;
  localparam int AW = 10;
  localparam int IW = 4;
  localparam int LIMIT = 20000;

  logic                 clk = 1'b0;
  logic                 rst, wr_en, ld_en, start, mode;
  logic [AW-1:0]        wr_addr;
  logic signed [WW-1:0] wr_data;
  logic [N-1:0]         ld_pattern;
  logic                 busy, done, converged;
  logic [IW-1:0]        iter_count;
  logic [N-1:0]         neuros;

  int checks = 0;
  int errors = 0;
  int dcyc;
  logic [N-1:0] pat, pflip, ones;

  always #5 clk = ~clk;

  hopfield_engine #(.N(N), .WW(WW), .MAX_ITER(15)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ld_en(ld_en), .ld_pattern(ld_pattern), .start(start), .mode(mode),
    .busy(busy), .done(done), .converged(converged), .iter_count(iter_count),
    .neuros(neuros)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // kind 0: Hebbian on pat, 1: all zero, 2: off-diagonal -1, 3: diagonal +5
  task automatic set_weights(input int kind);
    for (int k = 0; k < N; k++) begin
      for (int m = 0; m < N; m++) begin
        logic signed [WW-1:0] w;
        case (kind)
          0:       w = (k == m) ? 8'sd0 : ((pat[k] == pat[m]) ? 8'sd1 : -8'sd1);
          1:       w = 8'sd0;
          2:       w = (k == m) ? 8'sd0 : -8'sd1;
          default: w = (k == m) ? 8'sd5 : 8'sd0;
        endcase
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(k*N + m); wr_data = w;
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load(input logic [N-1:0] p);
    @(negedge clk);
    ld_en = 1'b1; ld_pattern = p;
    @(negedge clk);
    ld_en = 1'b0;
    chk("load_visible", neuros, p);
  endtask

  // act 1: pulse wr_en/ld_en at cycle 10; act 2: reset at cycle 300
  task automatic run(input logic md, input int act, input logic ldw,
                     input logic [N-1:0] p, output int dc);
    int c;
    logic aborted;
    aborted = 1'b0;
    dc = -1;
    @(negedge clk);
    start = 1'b1; mode = md;
    if (ldw) begin ld_en = 1'b1; ld_pattern = p; end
    @(negedge clk);
    start = 1'b0; ld_en = 1'b0;
    c = 1;
    chk("busy_cycle1", busy, 1);
    while (c < LIMIT && !done) begin
      if (act == 1 && c == 10) begin
        wr_en = 1'b1; wr_addr = AW'(1); wr_data = 8'sh7F;
        ld_en = 1'b1; ld_pattern = '0;
      end
      if (act == 2 && c == 300) rst = 1'b0;
      @(negedge clk);
      c++;
      if (act == 1 && c == 11) begin
        wr_en = 1'b0; ld_en = 1'b0;
        chk("ld_ignored_busy", neuros, p);
      end
      if (act == 2 && c == 301) begin
        rst = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_neuros", neuros, 0);
        chk("rst_done", done, 0);
        chk("rst_iter", iter_count, 0);
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      chk("done_seen", done, 1);
      dc = c;
      chk("busy_low_at_done", busy, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; ld_en = 1'b0; start = 1'b0; mode = 1'b0;
    wr_addr = '0; wr_data = '0; ld_pattern = '0;
    pat   = 25'h0E9C84E;
    pflip = pat ^ 25'h0100081;
    ones  = '1;
    repeat (3) @(negedge clk);
    chk("reset_neuros", neuros, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_conv", converged, 0);
    chk("reset_iter", iter_count, 0);
    rst = 1'b1;

    set_weights(0);
    load(pflip);
    run(1'b0, 0, 1'b0, pflip, dcyc);
    chk("hebb_neuros", neuros, pat);
    chk("hebb_conv", converged, 1);
    chk("hebb_iter", iter_count, 2);
    chk("hebb_done_cyc", dcyc, 1303);

    load(pflip);
    run(1'b0, 1, 1'b0, pflip, dcyc);
    chk("busy_wr_neuros", neuros, pat);
    chk("busy_wr_iter", iter_count, 2);

    load(pflip);
    run(1'b0, 2, 1'b0, pflip, dcyc);
    chk("abort_conv", converged, 0);
    run(1'b0, 0, 1'b1, pflip, dcyc);
    chk("rerun_neuros", neuros, pat);
    chk("rerun_conv", converged, 1);
    chk("rerun_done_cyc", dcyc, 1303);

    set_weights(1);
    load(ones);
    run(1'b0, 0, 1'b0, ones, dcyc);
    chk("zero_neuros", neuros, 0);
    chk("zero_conv", converged, 1);
    chk("zero_iter", iter_count, 2);

    set_weights(2);
    load(ones);
    run(1'b0, 0, 1'b0, ones, dcyc);
    chk("osc_conv", converged, 0);
    chk("osc_iter", iter_count, 15);
    chk("osc_done_cyc", dcyc, 15*651 + 1);
    chk("osc_neuros", neuros, 0);

    load(ones);
    run(1'b1, 0, 1'b0, ones, dcyc);
    chk("async_neuros", neuros, 25'h1FFE000);
    chk("async_conv", converged, 1);
    chk("async_iter", iter_count, 2);
    repeat (3) @(negedge clk);
    chk("conv_held", converged, 1);

    set_weights(3);
    load(ones);
    run(1'b0, 0, 1'b0, ones, dcyc);
`ifdef HOPFIELD_ZERO_DIAG_EN
    chk("diag_neuros", neuros, 0);
    chk("diag_iter", iter_count, 2);
    chk("diag_done_cyc", dcyc, 1303);
`else
    chk("diag_neuros", neuros, ones);
    chk("diag_iter", iter_count, 1);
    chk("diag_done_cyc", dcyc, 652);
`endif
    chk("diag_conv", converged, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
